serial_shift_unit: RTL and testbench

Multi-cycle, parametrised shift/rotate unit for the ALU datapath. It loads an operand, then shifts it by a programmable amount at one bit position per clock. It supports logical left/right, arithmetic right and left/right rotate, with a start/busy/done handshake. It replaces the fixed single-direction load/shift register wherever the ALU needs shift-by-N results without a combinational barrel shifter.

---
 rtl/alu_shift_pkg.sv | 20 ++
 rtl/serial_shift_unit_if.sv | 32 +++
 rtl/serial_shift_unit_step.sv | 45 ++++
 rtl/serial_shift_unit.sv | 107 ++++++++++
 tb/tb_serial_shift_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_shift_pkg.sv
// Shared types for the serial shift/rotate unit: shift modes, FSM states and mode width.
package alu_shift_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    SRA = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_shift_unit_if.sv
// Handshake/data bundle of the serial shift unit; carry exists only with SHIFT_CARRY_EN.
interface serial_shift_unit_if #(
  parameter int DATA_SIZE = 16
);
  import alu_shift_pkg::*;

  localparam int AMT_W = $clog2(DATA_SIZE);

  logic                 start;
  logic [MODE_W-1:0]    mode;
  logic [AMT_W-1:0]     amount;
  logic [DATA_SIZE-1:0] d;
  logic                 serial_in;
  logic                 clr;
  logic [DATA_SIZE-1:0] q;
  logic                 busy;
  logic                 done;
`ifdef SHIFT_CARRY_EN
  logic                 carry;

  modport master (output start, mode, amount, d, serial_in, clr,
                  input  q, busy, done, carry);
  modport slave  (input  start, mode, amount, d, serial_in, clr,
                  output q, busy, done, carry);
`else
  modport master (output start, mode, amount, d, serial_in, clr,
                  input  q, busy, done);
  modport slave  (input  start, mode, amount, d, serial_in, clr,
                  output q, busy, done);
`endif

endinterface

// File: rtl/serial_shift_unit_step.sv
// Combinational single-position shift/rotate step; out_bit exists only with SHIFT_CARRY_EN.
module shift_step
  import alu_shift_pkg::*;
#(
  parameter int DATA_SIZE = 16
) (
  input  logic [DATA_SIZE-1:0] q,
  input  logic [MODE_W-1:0]    mode,
  input  logic                 serial_in,
`ifdef SHIFT_CARRY_EN
  output logic                 out_bit,
`endif
  output logic [DATA_SIZE-1:0] q_next
);

  logic lsb_out;

  always_comb begin
    q_next  = q;
    lsb_out = 1'b1;
    case (mode)
      SLL: begin
        q_next  = {q[DATA_SIZE-2:0], serial_in};
        lsb_out = 1'b0;
      end
      SRL: q_next = {serial_in, q[DATA_SIZE-1:1]};
      SRA: q_next = {q[DATA_SIZE-1], q[DATA_SIZE-1:1]};
      ROL: begin
        q_next  = {q[DATA_SIZE-2:0], q[DATA_SIZE-1]};
        lsb_out = 1'b0;
      end
      ROR: q_next = {q[0], q[DATA_SIZE-1:1]};
      default: q_next = q;
    endcase
  end

`ifdef SHIFT_CARRY_EN
  // Left-going modes lose the MSB; everything else (reserved included) loses the LSB.
  assign out_bit = lsb_out ? q[0] : q[DATA_SIZE-1];
`else
  logic unused_lsb_out;
  assign unused_lsb_out = lsb_out;
`endif

endmodule

// File: rtl/serial_shift_unit.sv
// Serial shift/rotate unit: one bit position per clock, start/busy/done handshake.
// Optional carry output and register are built when SHIFT_CARRY_EN is defined.
module serial_shift_unit
  import alu_shift_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  localparam int AMT_W = $clog2(DATA_SIZE)
) (
  input logic                clk,
  input logic                rst,
  serial_shift_unit_if.slave bus
);

  state_t               state;
  logic [DATA_SIZE-1:0] q_r;
  logic [DATA_SIZE-1:0] step_q;
  logic [MODE_W-1:0]    mode_r;
  logic [AMT_W-1:0]     cnt;
  logic                 busy_r;
  logic                 done_r;
`ifdef SHIFT_CARRY_EN
  logic                 carry_r;
  logic                 step_out;
`endif

  shift_step #(.DATA_SIZE(DATA_SIZE)) u_step (
    .q         (q_r),
    .mode      (mode_r),
    .serial_in (bus.serial_in),
`ifdef SHIFT_CARRY_EN
    .out_bit   (step_out),
`endif
    .q_next    (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      q_r     <= '0;
      mode_r  <= '0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef SHIFT_CARRY_EN
      carry_r <= 1'b0;
`endif
    end else if (bus.clr) begin
      state   <= IDLE;
      q_r     <= '0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef SHIFT_CARRY_EN
      carry_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
          // DONE accepts a new start directly, giving back-to-back operation.
          if (bus.start) begin
            q_r    <= bus.d;
            mode_r <= bus.mode;
`ifdef SHIFT_CARRY_EN
            carry_r <= 1'b0;
`endif
            if (bus.amount == '0) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              state  <= SHIFT;
              cnt    <= bus.amount;
              busy_r <= 1'b1;
            end
          end
        end
        SHIFT: begin
          q_r <= step_q;
          cnt <= cnt - AMT_W'(1);
`ifdef SHIFT_CARRY_EN
          carry_r <= step_out;
`endif
          if (cnt == AMT_W'(1)) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q    = q_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
`ifdef SHIFT_CARRY_EN
  assign bus.carry = carry_r;
`endif

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed bench for serial_shift_unit (DATA_SIZE=8) with a per-cycle reference model.
module tb_serial_shift_unit;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  serial_shift_unit_if #(.DATA_SIZE(N)) bus ();

  serial_shift_unit #(.DATA_SIZE(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int issue_k = 0;
  logic chk_en = 1'b0;

  // Reference: the most recently accepted operation and the edge it was accepted on.
  logic       m_op = 1'b0;
  int         m_k = 0;
  int         m_amt = 0;
  logic [2:0] m_mode = 3'd0;
  logic [7:0] m_d = 8'd0;
  logic       m_si = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Result of applying n steps of mode md to dv, with a constant fill bit si.
  function automatic logic [7:0] f_q(input logic [7:0] dv, input logic [2:0] md,
                                     input int n, input logic si);
    int x;
    int r;
    x = int'(dv);
    case (md)
      3'd0:    r = (x << n) | (si ? ((1 << n) - 1) : 0);
      3'd1:    r = (x >> n) | (si ? (255 & ~(255 >> n)) : 0);
      3'd2:    r = (x >> n) | (dv[7] ? (255 & ~(255 >> n)) : 0);
      3'd3:    r = (x << n) | (x >> (8 - n));
      3'd4:    r = (x >> n) | (x << (8 - n));
      default: r = x;
    endcase
    return 8'(r);
  endfunction

  // Bit of the original operand that leaves on step n.
  function automatic logic f_c(input logic [7:0] dv, input logic [2:0] md, input int n);
    if (n == 0) return 1'b0;
    if (md == 3'd0 || md == 3'd3) return dv[8-n];
    if (md == 3'd1 || md == 3'd2 || md == 3'd4) return dv[n-1];
    return dv[0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_op <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (bus.clr) begin
        m_op <= 1'b0;
      end else if (bus.start && (!m_op || (cyc + 1 - m_k) > m_amt)) begin
        m_op   <= 1'b1;
        m_k    <= cyc + 1;
        m_amt  <= int'(bus.amount);
        m_mode <= bus.mode;
        m_d    <= bus.d;
        m_si   <= bus.serial_in;
      end
    end
  end

  always @(negedge clk) begin
    int n;
    if (chk_en) begin
      if (!m_op) begin
        check("cyc_q_cleared", 32'(bus.q), 32'd0);
        check("cyc_busy_idle", 32'(bus.busy), 32'd0);
        check("cyc_done_idle", 32'(bus.done), 32'd0);
`ifdef SHIFT_CARRY_EN
        check("cyc_carry_cleared", 32'(bus.carry), 32'd0);
`endif
      end else begin
        n = cyc - m_k;
        if (n > m_amt) n = m_amt;
        check("cyc_q", 32'(bus.q), 32'(f_q(m_d, m_mode, n, m_si)));
        check("cyc_busy", 32'(bus.busy), 32'((cyc - m_k) < m_amt));
        check("cyc_done", 32'(bus.done), 32'((cyc - m_k) == m_amt));
`ifdef SHIFT_CARRY_EN
        check("cyc_carry", 32'(bus.carry), 32'(f_c(m_d, m_mode, n)));
`endif
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic issue(input logic [2:0] md, input int amt, input logic [7:0] dv, input logic si);
    bus.start     = 1'b1;
    bus.mode      = md;
    bus.amount    = 3'(amt);
    bus.d         = dv;
    bus.serial_in = si;
    @(negedge clk);
    bus.start = 1'b0;
    issue_k   = cyc;
  endtask

  task automatic wait_done(input string nm, input int amt, input logic [7:0] exp_q,
                           input logic exp_c);
    logic found;
    found = 1'b0;
    for (int i = 0; i <= amt + 3; i++) begin
      if (bus.done) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      check({nm, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      check({nm, "_latency"}, 32'(cyc - issue_k), 32'(amt));
      check({nm, "_q"}, 32'(bus.q), 32'(exp_q));
`ifdef SHIFT_CARRY_EN
      check({nm, "_carry"}, 32'(bus.carry), 32'(exp_c));
`else
      if (exp_c !== 1'bx) tests = tests + 0;
`endif
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] md, input int amt,
                        input logic [7:0] dv, input logic si,
                        input logic [7:0] exp_q, input logic exp_c);
    @(negedge clk);
    issue(md, amt, dv, si);
    wait_done(nm, amt, exp_q, exp_c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.mode = 3'd0;
    bus.amount = 3'd0;
    bus.d = 8'd0;
    bus.serial_in = 1'b0;
    bus.clr = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_q", 32'(bus.q), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_op("sll_81_3", 3'd0, 3, 8'h81, 1'b0, 8'h08, 1'b0);
    run_op("sra_90_2", 3'd2, 2, 8'h90, 1'b0, 8'hE4, 1'b0);
    run_op("ror_01_1", 3'd4, 1, 8'h01, 1'b0, 8'h80, 1'b1);
    run_op("srl_00_4", 3'd1, 4, 8'h00, 1'b1, 8'hF0, 1'b0);
    run_op("amt0_5a", 3'd0, 0, 8'h5A, 1'b0, 8'h5A, 1'b0);
    run_op("rol_b4_3", 3'd3, 3, 8'hB4, 1'b0, 8'hA5, 1'b1);
    run_op("sll_fill_7", 3'd0, 7, 8'h00, 1'b1, 8'h7F, 1'b0);
    run_op("reserved5", 3'd5, 2, 8'h3C, 1'b0, 8'h3C, 1'b0);

    // start pulsed mid-shift with a different operand must be ignored
    @(negedge clk);
    issue(3'd1, 4, 8'hF0, 1'b0);
    bus.start = 1'b1;
    bus.d = 8'hAA;
    bus.mode = 3'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("busy_start_ignored", 4, 8'h0F, 1'b0);

    // second start presented while done is high: loads with no idle cycle
    @(negedge clk);
    issue(3'd0, 2, 8'h03, 1'b0);
    wait_done("b2b_first", 2, 8'h0C, 1'b0);
    issue(3'd4, 2, 8'h03, 1'b0);
    check("b2b_busy_immediate", 32'(bus.busy), 32'd1);
    wait_done("b2b_second", 2, 8'hC0, 1'b1);

    // asynchronous reset during the second shift of a 5-step operation
    @(negedge clk);
    issue(3'd0, 5, 8'h0F, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_q", 32'(bus.q), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst_sra", 3'd2, 7, 8'h7F, 1'b0, 8'h00, 1'b1);

    // synchronous clear mid-shift: back to idle, no done pulse afterwards
    @(negedge clk);
    issue(3'd1, 5, 8'hFF, 1'b0);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("clr_q", 32'(bus.q), 32'd0);
    check("clr_busy", 32'(bus.busy), 32'd0);
    check("clr_done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("clr_no_done", 32'(bus.done), 32'd0);
    end

    run_op("final_rol_1", 3'd3, 1, 8'h80, 1'b0, 8'h01, 1'b1);
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
